cnn_window_streamer: RTL and testbench
======================================

Name: cnn_window_streamer

Overview:
Hardware replacement for bench-side window extraction ahead of simpleCNN. Accepts one raster-order image frame as a pixel stream with valid/ready handshake and stores it in an internal frame buffer. Then emits every KxK convolution window in raster order with configurable stride and zero padding, along with the window origin, again under valid/ready. Output packing matches the IMGIN convention of simpleCNN.

Parameters:
IMG_W, 28, image width in pixels (columns)
IMG_H, 28, image height in pixels (rows)
K, 5, window edge length; 1 <= K <= min(IMG_W, IMG_H)
PW, 8, pixel width in bits
STRIDE, 1, window step in both directions; >= 1
PAD, 0, zero-padding border width; 0 <= PAD <= K-1
CW, 5, coordinate width; must satisfy 2^CW > max(IMG_W, IMG_H) + 2*PAD

Ports:
CLK  input  1  clock; all logic on rising edge
RST  input  1  asynchronous reset, active-high
START  input  1  begin a frame; sampled only in IDLE
PIX_IN  input  PW  input pixel
PIX_VALID  input  1  PIX_IN valid
PIX_READY  output  1  block accepts a pixel this cycle
WIN  output  K*K*PW  window; element (i,j) at bits [(i*K+j)*PW +: PW], i = row offset, j = column offset
X  output  CW  window origin row, padded coordinates (0 = first output row)
Y  output  CW  window origin column, padded coordinates
WIN_VALID  output  1  WIN/X/Y valid
WIN_READY  input  1  consumer accepts the window
BUSY  output  1  high in LOAD and EMIT
DONE  output  1  one-cycle pulse after the last window handshake

Behaviour:
- Reset (asynchronous, any state): state=IDLE; PIX_READY=0, WIN_VALID=0, BUSY=0, DONE=0; WIN=0, X=0, Y=0; counters cleared. Frame buffer contents are don't-care.
- States: IDLE, LOAD, EMIT, FIN.
- IDLE:
  - START=1 -> LOAD next cycle.
  - PIX_VALID is ignored; PIX_READY=0.
- LOAD:
  - PIX_READY=1.
  - Each PIX_VALID&PIX_READY cycle writes buffer[r][c] and advances c; on c wrap, c=0 and r++.
  - When pixel IMG_W*IMG_H-1 is accepted -> EMIT.
  - PIX_VALID gaps stall without loss.
  - START is ignored.
- EMIT:
  - In the first EMIT cycle (the cycle after the final pixel handshake), the registered window for origin (0,0) is presented with WIN_VALID=1.
  - Window at origin (X,Y): element (i,j) = buffer[X*STRIDE+i-PAD][Y*STRIDE+j-PAD] when that index is inside the image; otherwise 0.
  - Output grid: NR = (IMG_H+2*PAD-K)/STRIDE+1 rows by NC = (IMG_W+2*PAD-K)/STRIDE+1 columns (integer floor). X is a grid index in 0..NR-1 and Y in 0..NC-1; both count in windows, not pixels.
  - Scan order: Y inner, X outer.
  - While WIN_VALID=1 and WIN_READY=0, WIN/X/Y/WIN_VALID hold stable.
  - On handshake, the next window appears the following cycle. Sustained throughput is 1 window per cycle.
  - Handshake on window (NR-1, NC-1) -> FIN, with WIN_VALID=0 next cycle.
- FIN: DONE=1 for exactly one cycle -> IDLE. START in FIN is ignored.
- PIX_READY and WIN_VALID are never both 1.
- BUSY=1 in LOAD and EMIT only.
- Reset mid-LOAD or mid-EMIT: aborts immediately. No DONE is produced, and the next frame requires a new START.
- Defaults (28/28/5/1/0): 576 windows, X,Y in 0..23. Window (X,Y) covers image rows X..X+4 and columns Y..Y+4 exactly, with no off-by-one column shift.

Test Plan:
- Basic frame: defaults; pixel(r,c) = (r*28+c) mod 256, PIX_VALID held high.
  - Exactly 784 PIX_READY handshakes occur, then exactly 576 windows.
  - Window (0,0): element(0,0)=0x00, element(4,4)=0x74.
  - Window (23,23): element(0,0)=0x9B.
  - DONE pulses once, one cycle after the 576th handshake.
- Stride: STRIDE=2, same image.
  - 144 windows (12x12) are produced.
  - Window (1,1): element(0,0) = pixel(2,2) = 0x3A.
  - Last window origin reported as X=11, Y=11.
- Padding: PAD=2, same image.
  - 784 windows are produced.
  - Window (0,0): elements (0..1,*) and (*,0..1) = 0; element(2,3) = pixel(0,1) = 0x01.
  - Window (27,27): element(2,2) = pixel(27,27) = 0x0F; element(4,4) = 0.
- Handshake stress: random PIX_VALID at 50% duty and random WIN_READY at 30%.
  - WIN/X/Y remain stable while stalled.
  - No window is skipped or duplicated; the collected set equals the basic-frame reference.
- Control edges:
  - START pulsed during LOAD and EMIT is ignored, and the window count stays 576.
  - PIX_VALID in IDLE gives PIX_READY=0 and no writes.
  - Two back-to-back frames with different pixel data both produce correct windows.
- Reset mid-operation: assert RST at window 100 of EMIT.
  - All outputs drop to 0 asynchronously and no DONE is produced.
  - A following START plus a full frame yields a complete, correct 576-window run.

Source files
------------

// File: rtl/cnn_window_streamer.sv
`default_nettype none
// ============================================================================
//  Module   : cnn_window_streamer
//  Purpose  : Buffers one raster-order frame, then streams every KxK window
//             (stride, zero padding) with its origin under valid/ready.
//  Revision : 1.0  initial release
// ============================================================================
module cnn_window_streamer #(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int K      = 5,
    parameter int PW     = 8,
    parameter int STRIDE = 1,
    parameter int PAD    = 0,
    parameter int CW     = 5
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                START,
    input  logic [PW-1:0]       PIX_IN,
    input  logic                PIX_VALID,
    output logic                PIX_READY,
    output logic [K*K*PW-1:0]   WIN,
    output logic [CW-1:0]       X,
    output logic [CW-1:0]       Y,
    output logic                WIN_VALID,
    input  logic                WIN_READY,
    output logic                BUSY,
    output logic                DONE
);

    localparam int NR   = (IMG_H + 2*PAD - K) / STRIDE + 1;
    localparam int NC   = (IMG_W + 2*PAD - K) / STRIDE + 1;
    localparam int NPIX = IMG_W * IMG_H;
    localparam int AW   = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int WW   = K * K * PW;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_EMIT = 2'd2;
    localparam logic [1:0] S_FIN  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] row_q, row_d, col_q, col_d;
    logic [CW-1:0] x_q, x_d, y_q, y_d;
    logic [CW-1:0] nxt_x, nxt_y;
    logic [WW-1:0] win_q, win_d, win_nxt;
    logic [PW-1:0] mem_q [NPIX];
    logic          pix_hs, last_pix, last_win;
    logic [AW-1:0] wr_addr, rd_addr;
    int            rd_row, rd_col;

    assign pix_hs   = (state_q == S_LOAD) && PIX_VALID;
    assign last_pix = (row_q == CW'(IMG_H-1)) && (col_q == CW'(IMG_W-1));
    assign last_win = (x_q == CW'(NR-1)) && (y_q == CW'(NC-1));
    assign wr_addr  = AW'(int'(row_q) * IMG_W + int'(col_q));

    // Origin of the window to be registered next: (0,0) when leaving LOAD,
    // otherwise the raster successor of the window currently presented.
    always_comb begin
        if (state_q == S_LOAD) begin
            nxt_x = '0;
            nxt_y = '0;
        end else if (y_q == CW'(NC-1)) begin
            nxt_x = x_q + CW'(1);
            nxt_y = '0;
        end else begin
            nxt_x = x_q;
            nxt_y = y_q + CW'(1);
        end
    end

    // Window gather; the pixel being written this cycle is forwarded so the
    // first window is correct even when it covers the final pixel.
    always_comb begin
        win_nxt = '0;
        rd_row  = 0;
        rd_col  = 0;
        rd_addr = '0;
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
                rd_row  = int'(nxt_x) * STRIDE + i - PAD;
                rd_col  = int'(nxt_y) * STRIDE + j - PAD;
                rd_addr = '0;
                if (rd_row >= 0 && rd_row < IMG_H && rd_col >= 0 && rd_col < IMG_W) begin
                    rd_addr = AW'(rd_row * IMG_W + rd_col);
                    if (pix_hs && rd_addr == wr_addr) begin
                        win_nxt[(i*K+j)*PW +: PW] = PIX_IN;
                    end else begin
                        win_nxt[(i*K+j)*PW +: PW] = mem_q[rd_addr];
                    end
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        x_d     = x_q;
        y_d     = y_q;
        win_d   = win_q;
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    state_d = S_LOAD;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            S_LOAD: begin
                if (pix_hs) begin
                    if (col_q == CW'(IMG_W-1)) begin
                        col_d = '0;
                        row_d = row_q + CW'(1);
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                    if (last_pix) begin
                        state_d = S_EMIT;
                        x_d     = nxt_x;
                        y_d     = nxt_y;
                        win_d   = win_nxt;
                    end
                end
            end
            S_EMIT: begin
                if (WIN_READY) begin
                    if (last_win) begin
                        state_d = S_FIN;
                        x_d     = '0;
                        y_d     = '0;
                        win_d   = '0;
                    end else begin
                        x_d     = nxt_x;
                        y_d     = nxt_y;
                        win_d   = win_nxt;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Frame storage carries no reset; every location is rewritten per frame.
    always_ff @(posedge CLK) begin
        if (pix_hs) begin
            mem_q[wr_addr] <= PIX_IN;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            win_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            x_q     <= x_d;
            y_q     <= y_d;
            win_q   <= win_d;
        end
    end

    assign PIX_READY = (state_q == S_LOAD);
    assign WIN_VALID = (state_q == S_EMIT);
    assign BUSY      = (state_q == S_LOAD) || (state_q == S_EMIT);
    assign DONE      = (state_q == S_FIN);
    assign WIN       = win_q;
    assign X         = x_q;
    assign Y         = y_q;

endmodule
`default_nettype wire

// File: tb/tb_cnn_window_streamer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cnn_window_streamer
//  Purpose  : Self-checking bench; three instances (default, stride 2, pad 2)
//             share stimulus and are scored against a reference window model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cnn_window_streamer;

    localparam int NPIX = 784;
    localparam int WB   = 200;

    logic       clk = 1'b0;
    logic       rst, start, pix_valid, win_ready;
    logic [7:0] pix_in;
    logic       pr [3];
    logic       wv [3];
    logic       busy [3];
    logic       done [3];
    logic [WB-1:0] win [3];
    logic [4:0] x0, y0, x1, y1;
    logic [5:0] x2, y2;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int ex [3];
    int ey [3];
    int cnt [3];
    int lasths [3];
    int donecnt [3];
    int lastx [3];
    int lasty [3];
    logic [7:0]    img [NPIX];
    logic [WB-1:0] cap [3][NPIX];
    bit            stall_prev = 1'b0;
    logic [WB-1:0] hw;
    int            hx, hy;

    typedef struct {
        int         d;
        int         x;
        int         y;
        int         i;
        int         j;
        logic [7:0] exp;
        string      nm;
    } spot_t;
    spot_t tbl [10];

    always #5 clk = ~clk;

    cnn_window_streamer #(.STRIDE(1), .PAD(0), .CW(5)) u_d0 (
        .CLK(clk), .RST(rst), .START(start), .PIX_IN(pix_in), .PIX_VALID(pix_valid),
        .PIX_READY(pr[0]), .WIN(win[0]), .X(x0), .Y(y0), .WIN_VALID(wv[0]),
        .WIN_READY(win_ready), .BUSY(busy[0]), .DONE(done[0]));

    cnn_window_streamer #(.STRIDE(2), .PAD(0), .CW(5)) u_d1 (
        .CLK(clk), .RST(rst), .START(start), .PIX_IN(pix_in), .PIX_VALID(pix_valid),
        .PIX_READY(pr[1]), .WIN(win[1]), .X(x1), .Y(y1), .WIN_VALID(wv[1]),
        .WIN_READY(win_ready), .BUSY(busy[1]), .DONE(done[1]));

    cnn_window_streamer #(.STRIDE(1), .PAD(2), .CW(6)) u_d2 (
        .CLK(clk), .RST(rst), .START(start), .PIX_IN(pix_in), .PIX_VALID(pix_valid),
        .PIX_READY(pr[2]), .WIN(win[2]), .X(x2), .Y(y2), .WIN_VALID(wv[2]),
        .WIN_READY(win_ready), .BUSY(busy[2]), .DONE(done[2]));

    function automatic int st_of(int d);
        return (d == 1) ? 2 : 1;
    endfunction

    function automatic int pd_of(int d);
        return (d == 2) ? 2 : 0;
    endfunction

    function automatic int nr_of(int d);
        return (28 + 2*pd_of(d) - 5) / st_of(d) + 1;
    endfunction

    function automatic logic [7:0] ref_px(int d, int x, int y, int i, int j);
        int r, c;
        r = x*st_of(d) + i - pd_of(d);
        c = y*st_of(d) + j - pd_of(d);
        if (r < 0 || r >= 28 || c < 0 || c >= 28) return 8'h00;
        return img[r*28 + c];
    endfunction

    function automatic logic [WB-1:0] ref_win(int d, int x, int y);
        logic [WB-1:0] w;
        w = '0;
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
                w[(i*5+j)*8 +: 8] = ref_px(d, x, y, i, j);
        return w;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic mon(input int d, input logic v, input logic [WB-1:0] w,
                       input int x, input int y, input logic dn);
        logic [WB-1:0] rw;
        int nr;
        nr = nr_of(d);
        if (v && win_ready) begin
            checks++;
            if (x != ex[d] || y != ey[d]) begin
                errors++;
                $display("FAIL win_order d%0d actual=(%0d,%0d) required=(%0d,%0d)", d, x, y, ex[d], ey[d]);
            end
            rw = ref_win(d, ex[d], ey[d]);
            checks++;
            if (w !== rw) begin
                errors++;
                $display("FAIL win_data d%0d (%0d,%0d) actual=%h required=%h", d, ex[d], ey[d], w, rw);
            end
            if (cnt[d] < NPIX) cap[d][cnt[d]] = w;
            cnt[d]++;
            lasths[d] = cyc;
            lastx[d]  = x;
            lasty[d]  = y;
            if (ey[d] == nr-1) begin
                ey[d] = 0;
                ex[d]++;
            end else begin
                ey[d]++;
            end
        end
        if (dn) begin
            chk($sformatf("win_count_d%0d", d), 64'(cnt[d]), 64'(nr*nr));
            chk($sformatf("done_latency_d%0d", d), 64'(lasths[d]), 64'(cyc-1));
            donecnt[d]++;
            cnt[d] = 0;
            ex[d]  = 0;
            ey[d]  = 0;
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            for (int d = 0; d < 3; d++) begin
                ex[d]  = 0;
                ey[d]  = 0;
                cnt[d] = 0;
            end
            stall_prev = 1'b0;
        end else begin
            for (int d = 0; d < 3; d++)
                chk("rdy_vld_excl", 64'(pr[d] & wv[d]), 64'd0);
            mon(0, wv[0], win[0], int'(x0), int'(y0), done[0]);
            mon(1, wv[1], win[1], int'(x1), int'(y1), done[1]);
            mon(2, wv[2], win[2], int'(x2), int'(y2), done[2]);
            if (stall_prev && wv[0]) begin
                checks++;
                if (win[0] !== hw || int'(x0) != hx || int'(y0) != hy) begin
                    errors++;
                    $display("FAIL stall_hold actual=(%0d,%0d) required=(%0d,%0d)", x0, y0, hx, hy);
                end
            end
            stall_prev = wv[0] && !win_ready;
            hw = win[0];
            hx = int'(x0);
            hy = int'(y0);
        end
    end

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_pix_ready"}, 64'(pr[0]), 64'd0);
        chk({tag, "_win_valid"}, 64'(wv[0]), 64'd0);
        chk({tag, "_busy"},      64'(busy[0]), 64'd0);
        chk({tag, "_done"},      64'(done[0]), 64'd0);
        chk({tag, "_win"},       64'(|win[0]), 64'd0);
        chk({tag, "_x"},         64'(x0), 64'd0);
        chk({tag, "_y"},         64'(y0), 64'd0);
    endtask

    function automatic bit all_done(input int dc [3]);
        return donecnt[0] > dc[0] && donecnt[1] > dc[1] && donecnt[2] > dc[2];
    endfunction

    task automatic run_frame(input int vduty, input int rduty, input bit spam, input int abort_at);
        int dc [3];
        int idx, guard;
        dc = donecnt;
        @(posedge clk); #1;
        start = 1'b1; pix_valid = 1'b0; win_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        idx = 0;
        guard = 0;
        while (idx < NPIX && guard < 20000) begin
            pix_valid = ($urandom_range(99) < vduty);
            pix_in    = img[idx];
            start     = spam && ($urandom_range(7) == 0);
            @(negedge clk);
            if (pr[0] && pix_valid) idx++;
            @(posedge clk); #1;
            guard++;
        end
        chk("load_handshakes", 64'(idx), 64'(NPIX));
        pix_valid = 1'b0;
        start     = 1'b0;
        @(negedge clk);
        chk("first_win_valid", 64'(wv[0]), 64'd1);
        chk("first_pix_ready", 64'(pr[0]), 64'd0);
        guard = 0;
        while (!all_done(dc) && guard < 20000) begin
            @(posedge clk); #1;
            win_ready = ($urandom_range(99) < rduty);
            pix_valid = ($urandom_range(1) == 0);
            pix_in    = 8'($urandom);
            start     = spam && busy[0] && busy[1] && busy[2] && ($urandom_range(7) == 0);
            @(negedge clk); #1;
            if (abort_at >= 0 && cnt[0] >= abort_at) break;
            guard++;
        end
        start = 1'b0;
        pix_valid = 1'b0;
        if (abort_at < 0) begin
            win_ready = 1'b0;
            for (int d = 0; d < 3; d++)
                chk($sformatf("done_once_d%0d", d), 64'(donecnt[d] - dc[d]), 64'd1);
        end
    endtask

    task automatic fill_img(input bit alt);
        for (int r = 0; r < 28; r++)
            for (int c = 0; c < 28; c++)
                img[r*28+c] = alt ? 8'((r*7 + c*13 + 90) % 256) : 8'((r*28 + c) % 256);
    endtask

    initial begin
        int dc0;
        logic [WB-1:0] w;
        tbl[0] = '{0,  0,  0, 0, 0, 8'h00, "d0_w00_e00"};
        tbl[1] = '{0,  0,  0, 4, 4, 8'h74, "d0_w00_e44"};
        tbl[2] = '{0, 23, 23, 0, 0, 8'h9B, "d0_w2323_e00"};
        tbl[3] = '{1,  1,  1, 0, 0, 8'h3A, "s2_w11_e00"};
        tbl[4] = '{2,  0,  0, 0, 0, 8'h00, "p2_w00_e00"};
        tbl[5] = '{2,  0,  0, 1, 4, 8'h00, "p2_w00_e14"};
        tbl[6] = '{2,  0,  0, 4, 1, 8'h00, "p2_w00_e41"};
        tbl[7] = '{2,  0,  0, 2, 3, 8'h01, "p2_w00_e23"};
        tbl[8] = '{2, 27, 27, 2, 2, 8'h0F, "p2_w2727_e22"};
        tbl[9] = '{2, 27, 27, 4, 4, 8'h00, "p2_w2727_e44"};

        rst = 1'b1; start = 1'b0; pix_valid = 1'b0; win_ready = 1'b0; pix_in = 8'h00;
        fill_img(1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk_idle_outputs("reset");
        @(negedge clk); #2;
        rst = 1'b0;

        // Pixels offered in IDLE must be refused.
        pix_valid = 1'b1;
        pix_in    = 8'hFF;
        repeat (4) begin
            @(negedge clk);
            chk("idle_pix_ready", 64'(pr[0]), 64'd0);
        end
        pix_valid = 1'b0;

        run_frame(100, 100, 1'b0, -1);
        for (int t = 0; t < 10; t++) begin
            w = cap[tbl[t].d][tbl[t].x * nr_of(tbl[t].d) + tbl[t].y];
            chk(tbl[t].nm, 64'(w[(tbl[t].i*5 + tbl[t].j)*8 +: 8]), 64'(tbl[t].exp));
        end
        chk("d0_last_x", 64'(lastx[0]), 64'd23);
        chk("d0_last_y", 64'(lasty[0]), 64'd23);
        chk("s2_last_x", 64'(lastx[1]), 64'd11);
        chk("s2_last_y", 64'(lasty[1]), 64'd11);
        chk("p2_last_x", 64'(lastx[2]), 64'd27);

        run_frame(50, 30, 1'b0, -1);
        run_frame(100, 60, 1'b1, -1);

        fill_img(1'b1);
        run_frame(100, 100, 1'b0, -1);
        w = cap[0][0];
        chk("alt_w00_e12", 64'(w[(1*5+2)*8 +: 8]), 64'h7B);
        w = cap[0][575];
        chk("alt_w2323_e44", 64'(w[(4*5+4)*8 +: 8]), 64'h76);
        fill_img(1'b0);

        run_frame(100, 100, 1'b0, 100);
        chk("abort_in_emit", 64'(wv[0]), 64'd1);
        rst = 1'b1;
        #1;
        chk_idle_outputs("async_rst");
        repeat (2) @(posedge clk);
        @(negedge clk); #2;
        rst = 1'b0;
        win_ready = 1'b1;
        dc0 = donecnt[0];
        repeat (10) @(negedge clk);
        chk("no_done_after_abort", 64'(donecnt[0] - dc0), 64'd0);
        chk("idle_after_abort", 64'(busy[0]), 64'd0);
        win_ready = 1'b0;
        run_frame(100, 100, 1'b0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
